id_gen: RTL and testbench

ID_GEN -- requirements
Module: id_gen

---
 rtl/id_gen_pkg.sv | 38 +++
 rtl/bin2bcd8.sv | 29 ++
 rtl/id_gen.sv | 144 ++++++++++++++
 tb/tb_id_gen.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_gen_pkg.sv
// Shared definitions for the identifier generator and identifier recognizer:
// state encoding, ASCII class bounds and character-class helpers.
package id_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        DIGITS = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_0  = 8'd48;
    localparam logic [7:0] ASCII_9  = 8'd57;
    localparam logic [7:0] ASCII_UA = 8'd65;
    localparam logic [7:0] ASCII_UZ = 8'd90;
    localparam logic [7:0] ASCII_LA = 8'd97;
    localparam logic [7:0] ASCII_LZ = 8'd122;

    localparam int unsigned CHAR_W = 8;
    localparam int unsigned BCD_W  = 4;

    // Three decimal digits, most significant first.
    typedef struct packed {
        logic [BCD_W-1:0] hun;
        logic [BCD_W-1:0] ten;
        logic [BCD_W-1:0] one;
    } bcd3_t;

    function automatic logic is_letter(input logic [CHAR_W-1:0] c);
        return ((c >= ASCII_UA) && (c <= ASCII_UZ)) ||
               ((c >= ASCII_LA) && (c <= ASCII_LZ));
    endfunction

    function automatic logic is_digit(input logic [CHAR_W-1:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Combinational 8-bit binary to three-digit BCD converter (shift-and-add-3).
module bin2bcd8 (
    input  logic [7:0] bin,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [19:0] sh;

    // Digits live above the binary field; correct any digit >= 5 before each shift.
    always_comb begin
        sh = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sh[11:8] >= 4'd5) begin
                sh[11:8] = sh[11:8] + 4'd3;
            end
            if (sh[15:12] >= 4'd5) begin
                sh[15:12] = sh[15:12] + 4'd3;
            end
            sh = sh << 1;
        end
    end

    assign hundreds = sh[19:16];
    assign tens     = sh[15:12];
    assign ones     = sh[11:8];

endmodule

// File: rtl/id_gen.sv
// Identifier generator: streams a letter prefix followed by the decimal digits
// of a byte value over a valid/ready character interface.
module id_gen
    import id_gen_pkg::*;
#(
    parameter int unsigned PREFIX_MAX = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [8*PREFIX_MAX-1:0]   prefix,
    input  logic [2:0]                prefix_len,
    input  logic [7:0]                value,
    output logic [7:0]                char_out,
    output logic                      char_valid,
    input  logic                      char_ready,
    output logic                      char_last,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int unsigned PW = 8 * PREFIX_MAX;

    state_e         state;
    logic [PW-1:0]  pfx_q;
    logic [2:0]     pfx_rem;
    logic [11:0]    dig_q;
    logic [1:0]     dig_rem;

    bcd3_t          bcd;
    logic [11:0]    dig_seq;
    logic [1:0]     dig_cnt;
    logic           req_ok;
    logic           hs;

    bin2bcd8 u_bin2bcd8 (
        .bin      (value),
        .hundreds (bcd.hun),
        .tens     (bcd.ten),
        .ones     (bcd.one)
    );

    assign hs = char_valid & char_ready;

    // Request legality: length in range and every used prefix byte a letter.
    always_comb begin
        req_ok = 1'b1;
        if ((prefix_len == 3'd0) || (32'(prefix_len) > PREFIX_MAX)) begin
            req_ok = 1'b0;
        end
        for (int unsigned i = 0; i < PREFIX_MAX; i++) begin
            if ((i < 32'(prefix_len)) && !is_letter(prefix[i*8 +: 8])) begin
                req_ok = 1'b0;
            end
        end
    end

    // Left-align the significant digits; dig_cnt is the count after the first.
    always_comb begin
        dig_seq = {bcd.one, 8'h00};
        dig_cnt = 2'd0;
        if (bcd.hun != 4'd0) begin
            dig_seq = {bcd.hun, bcd.ten, bcd.one};
            dig_cnt = 2'd2;
        end else if (bcd.ten != 4'd0) begin
            dig_seq = {bcd.ten, bcd.one, 4'h0};
            dig_cnt = 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pfx_q      <= '0;
            pfx_rem    <= 3'd0;
            dig_q      <= 12'd0;
            dig_rem    <= 2'd0;
            char_out   <= 8'd0;
            char_valid <= 1'b0;
            char_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                // DONE behaves like IDLE for new requests, so back-to-back starts chain.
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        if (req_ok) begin
                            state      <= PREFIX;
                            char_out   <= prefix[7:0];
                            char_valid <= 1'b1;
                            char_last  <= 1'b0;
                            busy       <= 1'b1;
                            pfx_q      <= prefix >> 8;
                            pfx_rem    <= prefix_len - 3'd1;
                            dig_q      <= dig_seq;
                            dig_rem    <= dig_cnt;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                PREFIX: begin
                    if (hs) begin
                        if (pfx_rem == 3'd0) begin
                            state     <= DIGITS;
                            char_out  <= 8'(ASCII_0 + {4'd0, dig_q[11:8]});
                            char_last <= (dig_rem == 2'd0);
                            dig_q     <= dig_q << 4;
                        end else begin
                            char_out <= pfx_q[7:0];
                            pfx_q    <= pfx_q >> 8;
                            pfx_rem  <= pfx_rem - 3'd1;
                        end
                    end
                end
                DIGITS: begin
                    if (hs) begin
                        if (char_last) begin
                            state      <= DONE;
                            char_out   <= 8'd0;
                            char_valid <= 1'b0;
                            char_last  <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            char_out  <= 8'(ASCII_0 + {4'd0, dig_q[11:8]});
                            char_last <= (dig_rem == 2'd1);
                            dig_q     <= dig_q << 4;
                            dig_rem   <= dig_rem - 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_id_gen.sv
// Randomized self-checking bench for id_gen against a string-based reference
// model, with a behavioural identifier recognizer consuming the stream.
module tb_id_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] prefix;
    logic [2:0]  prefix_len;
    logic [7:0]  value;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready;
    logic        char_last;
    logic        busy;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_gen #(.PREFIX_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .prefix     (prefix),
        .prefix_len (prefix_len),
        .value      (value),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_last  (char_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    function automatic logic [31:0] pack4(input byte b0, input byte b1, input byte b2, input byte b3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic bit letter(input logic [7:0] c);
        return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
    endfunction

    function automatic bit model_ok(input logic [31:0] pfx, input int len);
        logic [7:0] b;
        if (len < 1 || len > 4) return 0;
        for (int i = 0; i < len; i++) begin
            b = pfx[8*i +: 8];
            if (!letter(b)) return 0;
        end
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready tied high, 1: toggling 1/0, 2: random ready plus stray starts.
    // chain=1 leaves the bench in the DONE cycle so a following start tests back-to-back.
    task automatic run_stream(input logic [31:0] pfx, input int len, input int val,
                              input int mode, input bit chain, input string name);
        byte        exp_q[$];
        string      s;
        int         n, idx, cyc;
        bit         rdy, prev_rdy, seen_letter, rec_out;
        logic [7:0] prev_out;
        logic       prev_valid, prev_last;

        for (int i = 0; i < len; i++) exp_q.push_back(pfx[8*i +: 8]);
        s = $sformatf("%0d", val);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        n = exp_q.size();

        start = 1'b1; prefix = pfx; prefix_len = 3'(len); value = 8'(val);
        char_ready = 1'b1;
        tick();
        start = 1'b0;
        prefix = $urandom; prefix_len = 3'($urandom); value = 8'($urandom);

        vectors++;
        if (char_valid !== 1'b1 || char_out !== exp_q[0] || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s first_char: valid=%b char=%0d busy=%b, want valid=1 char=%0d busy=1",
                     name, char_valid, char_out, busy, exp_q[0]);
        end

        idx = 0; cyc = 0; prev_rdy = 1'b1; seen_letter = 1'b0;
        prev_out = char_out; prev_valid = char_valid; prev_last = char_last;
        while (idx < n && cyc < 400) begin
            if (!prev_rdy) begin
                vectors++;
                if (char_out !== prev_out || char_valid !== prev_valid || char_last !== prev_last) begin
                    miscompares++;
                    $display("FAIL %s stall_hold: char=%0d valid=%b last=%b, want char=%0d valid=%b last=%b",
                             name, char_out, char_valid, char_last, prev_out, prev_valid, prev_last);
                end
            end
            vectors++;
            if (char_valid !== 1'b1 || char_out !== exp_q[idx] ||
                char_last !== (idx == n - 1) || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s char[%0d]: valid=%b char=%0d last=%b busy=%b, want valid=1 char=%0d last=%b busy=1",
                         name, idx, char_valid, char_out, char_last, busy, exp_q[idx], idx == n - 1);
            end

            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            char_ready = rdy;
            if (mode == 2) begin
                start = 1'($urandom_range(0, 1));
                prefix = pack4("a", "b", "c", "d");
                prefix_len = 3'd1;
                value = 8'($urandom);
            end

            if (rdy) begin
                rec_out = (char_out >= "0" && char_out <= "9") && seen_letter;
                if (letter(char_out)) seen_letter = 1'b1;
                vectors++;
                if (rec_out !== (idx >= len)) begin
                    miscompares++;
                    $display("FAIL %s recognizer[%0d]: out=%b want %b", name, idx, rec_out, idx >= len);
                end
            end

            prev_out = char_out; prev_valid = char_valid; prev_last = char_last; prev_rdy = rdy;
            tick();
            cyc++;
            if (rdy) idx++;
        end
        start = 1'b0;
        char_ready = 1'b1;

        vectors++;
        if (idx < n) begin
            miscompares++;
            $display("FAIL %s timeout: consumed %0d chars, want %0d", name, idx, n);
        end

        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || char_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_pulse: done=%b busy=%b valid=%b, want done=1 busy=0 valid=0",
                     name, done, busy, char_valid);
        end

        if (!chain) begin
            tick();
            vectors++;
            if (done !== 1'b0 || char_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL %s done_clear: done=%b valid=%b, want 0 0", name, done, char_valid);
            end
        end
    endtask

    task automatic check_reject(input logic [31:0] pfx, input int len, input int val, input string name);
        start = 1'b1; prefix = pfx; prefix_len = 3'(len); value = 8'(val);
        tick();
        start = 1'b0;
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0 || char_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s err_pulse: err=%b busy=%b valid=%b, want err=1 busy=0 valid=0",
                     name, err, busy, char_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (err !== 1'b0 || busy !== 1'b0 || char_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL %s after_reject: err=%b busy=%b valid=%b, want 0 0 0",
                         name, err, busy, char_valid);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; prefix = '0; prefix_len = 3'd0; value = 8'd0; char_ready = 1'b1;
        tick(); tick();
        vectors++;
        if (char_out !== 8'd0 || char_valid !== 1'b0 || char_last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: char=%0d valid=%b last=%b busy=%b done=%b err=%b, want all 0",
                     char_out, char_valid, char_last, busy, done, err);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        run_stream(pack4("a", "b", 0, 0), 2, 7, 0, 0, "ab7");
        run_stream(pack4("Z", 0, 0, 0), 1, 0, 0, 0, "Z0");
        run_stream(pack4("W", "x", "Y", "z"), 4, 255, 1, 0, "WxYz255");
        run_stream(pack4("q", 0, 0, 0), 1, 10, 1, 0, "q10");
    endtask

    task automatic test_reject();
        check_reject(pack4("a", "b", 0, 0), 0, 12, "len0");
        check_reject(pack4("5", 0, 0, 0), 1, 3, "digit_byte0");
        check_reject(pack4("a", "b", "c", "d"), 5, 3, "len5");
        check_reject(pack4("a", "b", "[", "d"), 3, 3, "bracket_byte2");
        run_stream(pack4("a", "b", "c", "1"), 3, 99, 0, 0, "unused_byte_ignored");
    endtask

    task automatic test_back_to_back();
        run_stream(pack4("M", "n", 0, 0), 2, 100, 0, 1, "b2b_first");
        run_stream(pack4("k", 0, 0, 0), 1, 5, 0, 0, "b2b_second");
    endtask

    task automatic test_reset_mid();
        start = 1'b1; prefix = pack4("a", "b", "c", 0); prefix_len = 3'd3; value = 8'd42;
        char_ready = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (char_valid !== 1'b0 || busy !== 1'b0 || char_out !== 8'd0 || char_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_async: valid=%b busy=%b char=%0d last=%b, want 0 0 0 0",
                     char_valid, busy, char_out, char_last);
        end
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (char_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_discard: valid=%b want 0", char_valid);
        end
        run_stream(pack4("X", "y", 0, 0), 2, 31, 0, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] pfx;
        int          len, val;
        for (int t = 0; t < 40; t++) begin
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 4));
            val = int'($urandom_range(0, 255));
            for (int b = 0; b < 4; b++) begin
                pfx[8*b +: 8] = $urandom_range(0, 1) ? 8'($urandom_range(65, 90)) : 8'($urandom_range(97, 122));
                if ($urandom_range(0, 9) == 0) pfx[8*b +: 8] = 8'($urandom);
            end
            if (model_ok(pfx, len)) run_stream(pfx, len, val, 2, 0, $sformatf("rand%0d", t));
            else check_reject(pfx, len, val, $sformatf("rand_rej%0d", t));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_reject();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
